// File: rtl/booth_mac_pkg.sv
// ============================================================================
// Module  : booth_mac_pkg
// Brief   : Shared types and constants for the Booth MAC datapath divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int   c_DEFAULT_DATA_WIDTH = 16;
    // Every quotient bit takes this value on divide-by-zero.
    localparam logic c_DZ_Q_BIT           = 1'b1;

endpackage

`default_nettype wire

// File: rtl/booth_div_signfix.sv
// ============================================================================
// Module  : booth_div_signfix
// Brief   : Operand magnitudes on entry and sign restoration of q/r on exit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_div_signfix
    import booth_mac_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  neg_q,
    input  logic                  neg_r,
    input  logic [DATA_WIDTH-1:0] q_mag,
    input  logic [DATA_WIDTH-1:0] r_mag,
    output logic [DATA_WIDTH-1:0] abs_a,
    output logic [DATA_WIDTH-1:0] abs_b,
    output logic [DATA_WIDTH-1:0] q_fix,
    output logic [DATA_WIDTH-1:0] r_fix
);

    // Magnitudes are read as unsigned, so |most negative| stays representable.
    assign abs_a = a[DATA_WIDTH-1] ? (~a + 1'b1) : a;
    assign abs_b = b[DATA_WIDTH-1] ? (~b + 1'b1) : b;

    assign q_fix = neg_q ? (~q_mag + 1'b1) : q_mag;
    assign r_fix = neg_r ? (~r_mag + 1'b1) : r_mag;

endmodule

`default_nettype wire

// File: rtl/booth_mac_divider.sv
// ============================================================================
// Module  : booth_mac_divider
// Brief   : Iterative non-restoring radix-2 divider, one quotient bit/clock.
//           Signed operation when BOOTH_DIV_SIGNED_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mac_divider
    import booth_mac_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] r,
    output logic                  dz,
    output logic                  done
);

    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_ITER = ITER;
    localparam logic [1:0] c_ST_FIX  = FIX;
    localparam logic [1:0] c_ST_DONE = DONE;

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH:0]   r_p;
    logic [DATA_WIDTH-1:0] r_qr;
    logic [DATA_WIDTH-1:0] r_abs_b;
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_r;
    logic                  r_dz;

    logic [DATA_WIDTH-1:0] w_abs_a;
    logic [DATA_WIDTH-1:0] w_abs_b;
    logic [DATA_WIDTH-1:0] w_r_mag;
    logic [DATA_WIDTH-1:0] w_q_out;
    logic [DATA_WIDTH-1:0] w_r_out;
    logic [DATA_WIDTH:0]   w_b_ext;
    logic [DATA_WIDTH:0]   w_shift_p;
    logic [DATA_WIDTH:0]   w_p_new;

    assign w_b_ext   = {1'b0, r_abs_b};
    assign w_shift_p = {r_p[DATA_WIDTH-1:0], r_qr[DATA_WIDTH-1]};
    assign w_p_new   = r_p[DATA_WIDTH] ? (w_shift_p + w_b_ext) : (w_shift_p - w_b_ext);

    // Restored remainder is non-negative and below |b|, so the low bits suffice.
    assign w_r_mag = r_p[DATA_WIDTH] ? (r_p[DATA_WIDTH-1:0] + r_abs_b) : r_p[DATA_WIDTH-1:0];

`ifdef BOOTH_DIV_SIGNED_EN
    logic r_neg_a;
    logic r_neg_b;

    booth_div_signfix #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_signfix (
        .a     (a),
        .b     (b),
        .neg_q (r_neg_a ^ r_neg_b),
        .neg_r (r_neg_a),
        .q_mag (r_qr),
        .r_mag (w_r_mag),
        .abs_a (w_abs_a),
        .abs_b (w_abs_b),
        .q_fix (w_q_out),
        .r_fix (w_r_out)
    );
`else
    assign w_abs_a = a;
    assign w_abs_b = b;
    assign w_q_out = r_qr;
    assign w_r_out = w_r_mag;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_p     <= '0;
            r_qr    <= '0;
            r_abs_b <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
`ifdef BOOTH_DIV_SIGNED_EN
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
`ifdef BOOTH_DIV_SIGNED_EN
                        r_neg_a <= a[DATA_WIDTH-1];
                        r_neg_b <= b[DATA_WIDTH-1];
`endif
                        if (b == '0) begin
                            r_q     <= {DATA_WIDTH{c_DZ_Q_BIT}};
                            r_r     <= a;
                            r_dz    <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_p     <= '0;
                            r_qr    <= w_abs_a;
                            r_abs_b <= w_abs_b;
                            r_state <= c_ST_ITER;
                        end
                    end
                end
                c_ST_ITER: begin
                    r_p  <= w_p_new;
                    r_qr <= {r_qr[DATA_WIDTH-2:0], ~w_p_new[DATA_WIDTH]};
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_FIX: begin
                    r_q     <= w_q_out;
                    r_r     <= w_r_out;
                    r_dz    <= 1'b0;
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign done = (r_state == c_ST_DONE);
    assign q    = r_q;
    assign r    = r_r;
    assign dz   = r_dz;

endmodule

`default_nettype wire
